// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-addressed memory, with
// read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT_BITS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_RD, ST_WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_misalign;
  logic        req_err;
  logic [31:0] align_mask;
  logic [4:0]  lane_sh;
  logic [31:0] lane_data;
  logic [31:0] ld_ext;
  logic [31:0] st_mask;
  logic [31:0] st_merged;

  always_comb begin
    req_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    align_mask = '1;
    req_err    = (req_size == 2'b11) || ((req_addr >> ADDR_LIMIT_BITS) != '0) || req_misalign;
`else
    // Without trapping, misaligned halves/words are silently rounded down.
    unique case (req_size)
      2'b01:   align_mask = 32'hFFFF_FFFE;
      2'b10:   align_mask = 32'hFFFF_FFFC;
      default: align_mask = '1;
    endcase
    req_err = (req_size == 2'b11) || ((req_addr >> ADDR_LIMIT_BITS) != '0) ||
              (req_misalign && 1'b0);
`endif
  end

  // addr_q is already aligned, so one byte-granular shift serves bytes and halves.
  assign lane_sh   = {addr_q[1:0], 3'b000};
  assign lane_data = mem_rdata >> lane_sh;

  always_comb begin
    unique case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   ld_ext = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
      default: ld_ext = mem_rdata;
    endcase
    st_mask   = (size_q == 2'b00) ? (32'h0000_00FF << lane_sh) : (32'h0000_FFFF << lane_sh);
    st_merged = (mem_rdata & ~st_mask) | ((wdata_q << lane_sh) & st_mask);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr & align_mask;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)               state_d = RESP;
          else if (!req_we)          state_d = LD_RD;
          else if (req_size == 2'b10) state_d = ST_WR;
          else                       state_d = ST_RD;
        end
      end
      LD_RD: begin
        mem_read = 1'b1;
        state_d  = LD_CAP;
      end
      LD_CAP: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      ST_RD: begin
        mem_read = 1'b1;
        state_d  = ST_WR;
      end
      ST_WR: begin
        mem_write = 1'b1;
        mem_wdata = (size_q == 2'b10) ? wdata_q : st_merged;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign mem_addr  = {2'b00, addr_q[31:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, directed
// cases followed by randomized traffic with random response backpressure.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.ADDR_LIMIT_BITS(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT: one-cycle read latency.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[15:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[15:0]];
  end

  // Reference model state: flat byte array, little-endian.
  logic [7:0]  refb [0:262143];
  logic [32:0] sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_hs = -10;
  bit          chk_b2b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_issue(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic err, output logic [31:0] rd,
                                    output logic [31:0] widx);
    int unsigned nb, ea;
    logic [31:0] v;
    bit misal;
    nb    = 1 << size;
    misal = (size != 2'b11) && ((addr % nb) != 0);
    err   = (size == 2'b11) || (addr >= 32'h0004_0000);
`ifdef LSU_MISALIGN_TRAP_EN
    err = err || misal;
`endif
    ea   = addr - (addr % nb);
    widx = ea / 4;
    rd   = 0;
    if (err) return;
    if (we) begin
      for (int unsigned i = 0; i < nb; i++) refb[ea + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int unsigned i = 0; i < nb; i++) v = v + (32'(refb[ea + i]) << (8 * i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
      rd = v;
    end
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
  endfunction

  // Monitor: every response handshake pops one expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        chk("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      $fatal(1, "FAIL req_ready never asserted");
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic e;
    logic [31:0] rd, widx;
    logic [7:0] rdm, wrm, erd, ewr;
    int first, elat;
    ref_issue(we, size, uns, addr, wdata, e, rd, widx);
    rsp_ready    = (hold == 0);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    wait_ready();
    if (chk_b2b) chk("b2b_accept_cycle", cyc + 1, last_hs + 1);
    chk_b2b = 1'b0;
    sb_q.push_back({e, rd});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom; req_size = 2'($urandom); req_unsigned = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    rdm = 0; wrm = 0; first = 0;
    for (int k = 1; k <= 8 && first == 0; k++) begin
      @(negedge clk);
      rdm[k-1] = mem_read;
      wrm[k-1] = mem_write;
      if (mem_read || mem_write) chk("mem_addr", mem_addr, widx);
      if (rsp_valid) first = k;
    end
    if (e)                    begin elat = 1; erd = 8'h00; ewr = 8'h00; end
    else if (!we)             begin elat = 3; erd = 8'h01; ewr = 8'h00; end
    else if (size == 2'b10)   begin elat = 2; erd = 8'h00; ewr = 8'h01; end
    else                      begin elat = 3; erd = 8'h01; ewr = 8'h02; end
    chk("rsp_latency", first, elat);
    chk("mem_read_cycles", {24'd0, rdm}, {24'd0, erd});
    chk("mem_write_cycles", {24'd0, wrm}, {24'd0, ewr});
    if (first == 0) begin
      void'(sb_q.pop_front());
      rsp_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_rsp_rdata", rsp_rdata, rd);
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
    end
    last_hs = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_rw"},    {30'd0, mem_read, mem_write}, 32'd0);
    chk({tag, "_mem_addr"},  mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] a, w;
    foreach (mem[i])  mem[i]  = '0;
    foreach (refb[i]) refb[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #13;
    chk_reset_vals("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 0);
    do_req(1'b1, 2'b11, 1'b0, 32'h30, 32'h5, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h8000_0010, 32'h7, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h33, 32'hBEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 5);
    chk_b2b = 1'b1;
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);

    // Reset during ST_WR of a byte store: the write must not land.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h55;
    wait_ready();
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_st_rd", {30'd0, mem_read, mem_write}, 32'd2);
    @(negedge clk);
    chk("abort_st_wr", {30'd0, mem_read, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_word", mem[16], ref_word(16));
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 19) == 0) a = a | (32'd1 << $urandom_range(18, 31));
      w = $urandom;
      do_req(1'($urandom), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
             1'($urandom), a, w, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    for (int unsigned wi = 0; wi < 64; wi++) chk("final_mem", mem[wi], ref_word(wi));
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
